// File: rtl/sys_defs.sv
// Shared fetch/instruction-buffer types: the IF->IB packet, fetch FSM states and fetch granule.
package sys_defs;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } IF_IB_PACKET;

  typedef enum logic [1:0] {IDLE, RUN, HALT} FETCH_STATE;

  localparam logic [31:0] FETCH_BYTES = 32'd8;

endpackage

// File: rtl/fetch_addr_fifo.sv
// In-order tag FIFO: one entry per fetch in flight, pushed on accept, popped on response.
module fetch_addr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Credit-based fetch sequencer: issues 8-byte fetches against buffer credits, drops
// responses that were in flight across a squash, and writes instruction pairs to the buffer.
module fetch_ctrl
  import sys_defs::*;
#(
  parameter int          IB_DEPTH  = 16,
  parameter int          MAX_OUTST = 4,
  parameter logic [31:0] RESET_PC  = 32'h0,
  localparam int         CW        = $clog2(IB_DEPTH) + 1,
  localparam int         OW        = $clog2(MAX_OUTST) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 squash,
  input  logic [31:0]          squash_pc,
  output logic                 mem_req_valid,
  output logic [31:0]          mem_req_addr,
  input  logic                 mem_req_ready,
  input  logic                 mem_rsp_valid,
  input  logic [63:0]          mem_rsp_data,
  input  logic                 ib_pop,
  output IF_IB_PACKET [1:0]    if_ib_packet,
  output logic [CW-1:0]        credits,
  output logic [OW-1:0]        outstanding
);

  localparam logic [CW-1:0] CRED_MAX = CW'(IB_DEPTH);
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTST);

  FETCH_STATE    state;
  logic [31:0]   fetch_pc;
  logic [OW-1:0] drop_cnt;
  logic          first_skip;
  logic          accept;
  logic          rsp_write;
  logic [31:0]   rsp_tag;
  logic [31:0]   rsp_base;
  logic          rsp_skip;
  logic          tag_unused;
  IF_IB_PACKET   pkt_lo;
  IF_IB_PACKET   pkt_hi;

  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] c,
                                                input logic take, input logic give);
    if (take && !give) return (c == '0) ? '0 : c - CW'(1);
    if (give && !take) return (c >= CRED_MAX) ? CRED_MAX : c + CW'(1);
    return c;
  endfunction

  assign mem_req_valid = (state == RUN) && !halt && !squash &&
                         (credits != '0) && (outstanding < OUT_MAX);
  assign mem_req_addr  = {fetch_pc[31:3], 3'b000};
  assign accept        = mem_req_valid && mem_req_ready;
  assign rsp_write     = mem_rsp_valid && !squash && (drop_cnt == '0);

  // The tag carries the line address plus whether its first instruction is skipped.
  fetch_addr_fifo #(.DEPTH(MAX_OUTST), .W(32)) u_addr_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data ({fetch_pc[31:3], first_skip, 2'b00}),
    .pop       (mem_rsp_valid),
    .head      (rsp_tag)
  );

  assign rsp_base   = {rsp_tag[31:3], 3'b000};
  assign rsp_skip   = rsp_tag[2];
  assign tag_unused = ^rsp_tag[1:0];

  always_comb begin
    pkt_lo = '{valid: rsp_write, inst: mem_rsp_data[31:0],
               PC: rsp_base, NPC: rsp_base + 32'd4};
    pkt_hi = '{valid: rsp_write, inst: mem_rsp_data[63:32],
               PC: rsp_base + 32'd4, NPC: rsp_base + 32'd8};
    if_ib_packet[0] = rsp_skip ? pkt_hi : pkt_lo;
    if_ib_packet[1] = pkt_hi;
    if_ib_packet[1].valid = rsp_write && !rsp_skip;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      credits     <= CRED_MAX;
      outstanding <= '0;
      drop_cnt    <= '0;
      first_skip  <= 1'b0;
    end else begin
      outstanding <= outstanding + OW'(accept) - OW'(mem_rsp_valid);
      if (squash) begin
        fetch_pc   <= squash_pc;
        first_skip <= squash_pc[2];
        credits    <= CRED_MAX;
        // outstanding already counts responses still owed to an earlier squash
        drop_cnt   <= outstanding - OW'(mem_rsp_valid);
        if (state != IDLE) state <= RUN;
      end else begin
        credits <= credit_next(credits, accept, ib_pop);
        if (accept) begin
          fetch_pc   <= {fetch_pc[31:3], 3'b000} + FETCH_BYTES;
          first_skip <= 1'b0;
        end
        if (mem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
        case (state)
          IDLE:    if (start) state <= RUN;
          RUN:     if (halt)  state <= HALT;
          HALT:    if (!halt) state <= RUN;
          default: state <= IDLE;
        endcase
      end
    end
  end

  rsp_needs_outstanding: assert property (@(posedge clock) disable iff (reset)
    mem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboarded bench for fetch_ctrl: a latency-programmable memory model queues each accepted
// fetch with its expected drop/skip treatment and checks the buffer write when it returns.
module tb_fetch_ctrl;
  import sys_defs::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              halt;
  logic              squash;
  logic [31:0]       squash_pc;
  logic              mem_req_valid;
  logic [31:0]       mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [63:0]       mem_rsp_data;
  logic              ib_pop;
  IF_IB_PACKET [1:0] if_ib_packet;
  logic [4:0]        credits;
  logic [2:0]        outstanding;

  fetch_ctrl #(.IB_DEPTH(16), .MAX_OUTST(4), .RESET_PC(32'h0)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .halt          (halt),
    .squash        (squash),
    .squash_pc     (squash_pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .ib_pop        (ib_pop),
    .if_ib_packet  (if_ib_packet),
    .credits       (credits),
    .outstanding   (outstanding)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        skip;
    logic        drop;
    int          due;
  } req_t;

  req_t pend[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rsp_lat = 2;
  int   drops_seen = 0;
  int   writes_seen = 0;
  logic tb_skip = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory model and scoreboard: records accepts at mid-cycle, presents responses after the edge.
  initial begin
    req_t        r;
    IF_IB_PACKET e0;
    IF_IB_PACKET e1;
    logic [31:0] a;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend.delete();
        tb_skip = 1'b0;
      end else begin
        if (squash) begin
          foreach (pend[i]) pend[i].drop = 1'b1;
          tb_skip = squash_pc[2];
        end
        if (mem_rsp_valid) begin
          total++;
          if (pend.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: response with empty model queue");
          end else begin
            r = pend.pop_front();
            a = r.addr;
            e0 = '{valid: 1'b1, inst: a ^ 32'h1357_0000, PC: a, NPC: a + 32'd4};
            e1 = '{valid: 1'b1, inst: (a + 32'd4) ^ 32'h2468_0000, PC: a + 32'd4, NPC: a + 32'd8};
            if (r.drop) begin
              drops_seen++;
              if (if_ib_packet[0].valid !== 1'b0 || if_ib_packet[1].valid !== 1'b0)
                begin bad++; $display("FAIL rsp_drop addr=%h got valids=%b%b want 00", a,
                                      if_ib_packet[1].valid, if_ib_packet[0].valid); end
            end else if (r.skip) begin
              writes_seen++;
              if (if_ib_packet[0] !== e1 || if_ib_packet[1].valid !== 1'b0)
                begin bad++; $display("FAIL rsp_skip addr=%h got=%h/%b want=%h/0", a,
                                      if_ib_packet[0], if_ib_packet[1].valid, e1); end
            end else begin
              writes_seen++;
              if (if_ib_packet[0] !== e0 || if_ib_packet[1] !== e1)
                begin bad++; $display("FAIL rsp_pair addr=%h got=%h %h want=%h %h", a,
                                      if_ib_packet[0], if_ib_packet[1], e0, e1); end
            end
          end
        end else begin
          total++;
          if (if_ib_packet[0].valid !== 1'b0 || if_ib_packet[1].valid !== 1'b0)
            begin bad++; $display("FAIL idle_write got valids=%b%b want 00",
                                  if_ib_packet[1].valid, if_ib_packet[0].valid); end
        end
        if (mem_req_valid && mem_req_ready) begin
          r.addr = mem_req_addr;
          r.skip = tb_skip;
          r.drop = 1'b0;
          r.due  = cyc + rsp_lat;
          tb_skip = 1'b0;
          pend.push_back(r);
        end
      end
      @(posedge clock); #1;
      if (!reset && pend.size() != 0 && pend[0].due <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {(pend[0].addr + 32'd4) ^ 32'h2468_0000, pend[0].addr ^ 32'h1357_0000};
      end else begin
        mem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic cycle();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; halt = 1'b0; squash = 1'b0; squash_pc = '0;
    mem_req_ready = 1'b0; ib_pop = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int w = 0;
    mem_req_ready = 1'b0;
    while (outstanding != 0 && w < 60) begin cycle(); w++; end
    ok = (outstanding == 0);
  endtask

  task automatic test_reset();
    do_reset();
    mem_req_ready = 1'b1;
    @(negedge clock);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", mem_req_valid); end
    total++; if (credits !== 5'd16) begin bad++; $display("FAIL reset_credits got=%0d want=16", credits); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
    repeat (3) cycle();
    @(negedge clock);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL idle_no_start got=%b want=0", mem_req_valid); end
    cycle();
  endtask

  task automatic test_fill();
    int n = 0;
    logic [31:0] exp_addr = 32'h0;
    int w0;
    do_reset();
    w0 = writes_seen;
    rsp_lat = 2;
    mem_req_ready = 1'b1;
    pulse_start();
    repeat (40) begin
      @(negedge clock);
      if (mem_req_valid && mem_req_ready) begin
        total++;
        if (mem_req_addr !== exp_addr) begin bad++; $display("FAIL fill_addr got=%h want=%h", mem_req_addr, exp_addr); end
        exp_addr += 32'd8;
        n++;
      end
      cycle();
    end
    @(negedge clock);
    total++; if (n !== 16) begin bad++; $display("FAIL fill_count got=%0d want=16", n); end
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL fill_stop got=%b want=0", mem_req_valid); end
    total++; if (credits !== 5'd0) begin bad++; $display("FAIL fill_credits got=%0d want=0", credits); end
    total++; if (writes_seen - w0 !== 16) begin bad++; $display("FAIL fill_writes got=%0d want=16", writes_seen - w0); end
    cycle();
  endtask

  task automatic test_credit();
    logic [4:0] peak = '0;
    bit ok;
    ib_pop = 1'b1;
    @(negedge clock);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL credit_zero_issue got=%b want=0", mem_req_valid); end
    cycle();
    total++; if (credits !== 5'd1) begin bad++; $display("FAIL credit_pop_only got=%0d want=1", credits); end
    @(negedge clock);
    total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL credit_accept got=%b want=1", mem_req_valid); end
    cycle();
    total++; if (credits !== 5'd1) begin bad++; $display("FAIL credit_pop_accept got=%0d want=1", credits); end
    ib_pop = 1'b0;
    cycle();
    total++; if (credits !== 5'd0) begin bad++; $display("FAIL credit_accept_only got=%0d want=0", credits); end
    mem_req_ready = 1'b0;
    ib_pop = 1'b1;
    repeat (24) begin
      cycle();
      if (credits > peak) peak = credits;
    end
    ib_pop = 1'b0;
    total++; if (peak > 5'd16) begin bad++; $display("FAIL credit_saturate got=%0d want<=16", peak); end
    total++; if (credits !== 5'd16) begin bad++; $display("FAIL credit_full got=%0d want=16", credits); end
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL credit_drain got=%0d want=0", outstanding); end
  endtask

  task automatic test_stall();
    int n = 0;
    int w = 0;
    bit ok;
    do_reset();
    rsp_lat = 10;
    pulse_start();
    repeat (5) begin
      @(negedge clock);
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0)
        begin bad++; $display("FAIL stall_hold got=%b/%h want=1/00000000", mem_req_valid, mem_req_addr); end
      cycle();
    end
    mem_req_ready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      total++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'(n * 8))
        begin bad++; $display("FAIL stall_burst got=%b/%h want=1/%h", mem_req_valid, mem_req_addr, 32'(n * 8)); end
      n++;
      cycle();
    end
    @(negedge clock);
    total++;
    if (mem_req_valid !== 1'b0 || outstanding !== 3'd4)
      begin bad++; $display("FAIL stall_limit got=%b/%0d want=0/4", mem_req_valid, outstanding); end
    while (!mem_req_valid && w < 30) begin cycle(); @(negedge clock); w++; end
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h20 || outstanding !== 3'd3 || w < 3)
      begin bad++; $display("FAIL stall_resume got=%b/%h/%0d want=1/00000020/3", mem_req_valid, mem_req_addr, outstanding); end
    cycle();
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_drain got=%0d want=0", outstanding); end
  endtask

  task automatic test_squash();
    int n = 0;
    int d0;
    int w0;
    bit ok;
    do_reset();
    d0 = drops_seen; w0 = writes_seen;
    rsp_lat = 8;
    mem_req_ready = 1'b1;
    pulse_start();
    repeat (3) begin
      @(negedge clock);
      if (mem_req_valid) n++;
      cycle();
    end
    mem_req_ready = 1'b0;
    total++;
    if (n !== 3 || outstanding !== 3'd3) begin bad++; $display("FAIL squash_setup got=%0d/%0d want=3/3", n, outstanding); end
    squash = 1'b1; squash_pc = 32'h104; mem_req_ready = 1'b1;
    @(negedge clock);
    total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL squash_no_issue got=%b want=0", mem_req_valid); end
    cycle();
    squash = 1'b0;
    total++; if (credits !== 5'd16) begin bad++; $display("FAIL squash_credits got=%0d want=16", credits); end
    @(negedge clock);
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100)
      begin bad++; $display("FAIL squash_redirect got=%b/%h want=1/00000100", mem_req_valid, mem_req_addr); end
    cycle();
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL squash_drain got=%0d want=0", outstanding); end
    total++; if (drops_seen - d0 !== 3) begin bad++; $display("FAIL squash_drops got=%0d want=3", drops_seen - d0); end
    total++; if (writes_seen - w0 !== 1) begin bad++; $display("FAIL squash_writes got=%0d want=1", writes_seen - w0); end
  endtask

  task automatic test_squash_rsp();
    int w = 0;
    int d0;
    int w0;
    bit ok;
    do_reset();
    d0 = drops_seen; w0 = writes_seen;
    rsp_lat = 3;
    mem_req_ready = 1'b1;
    pulse_start();
    repeat (2) begin @(negedge clock); cycle(); end
    mem_req_ready = 1'b0;
    #1;
    while (!mem_rsp_valid && w < 10) begin @(posedge clock); #2; w++; end
    total++;
    if (mem_rsp_valid !== 1'b1 || outstanding !== 3'd2)
      begin bad++; $display("FAIL sqrsp_setup got=%b/%0d want=1/2", mem_rsp_valid, outstanding); end
    squash = 1'b1; squash_pc = 32'h200;
    @(negedge clock);
    total++;
    if (if_ib_packet[0].valid !== 1'b0 || mem_req_valid !== 1'b0)
      begin bad++; $display("FAIL sqrsp_no_write got=%b/%b want=0/0", if_ib_packet[0].valid, mem_req_valid); end
    cycle();
    squash = 1'b0;
    total++;
    if (credits !== 5'd16 || outstanding !== 3'd1)
      begin bad++; $display("FAIL sqrsp_counters got=%0d/%0d want=16/1", credits, outstanding); end
    drain(ok);
    total++;
    if (!ok || drops_seen - d0 !== 2 || writes_seen - w0 !== 0)
      begin bad++; $display("FAIL sqrsp_drops got=%0d/%0d want=2/0", drops_seen - d0, writes_seen - w0); end
    mem_req_ready = 1'b1;
    @(negedge clock);
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200)
      begin bad++; $display("FAIL sqrsp_redirect got=%b/%h want=1/00000200", mem_req_valid, mem_req_addr); end
    cycle();
    drain(ok);
    total++;
    if (!ok || writes_seen - w0 !== 1) begin bad++; $display("FAIL sqrsp_after got=%0d want=1", writes_seen - w0); end
  endtask

  task automatic test_halt();
    int w = 0;
    int w0;
    bit ok;
    do_reset();
    w0 = writes_seen;
    rsp_lat = 4;
    mem_req_ready = 1'b1;
    pulse_start();
    repeat (2) begin @(negedge clock); cycle(); end
    halt = 1'b1;
    total++; if (outstanding !== 3'd2) begin bad++; $display("FAIL halt_setup got=%0d want=2", outstanding); end
    repeat (8) begin
      @(negedge clock);
      total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL halt_no_issue got=%b want=0", mem_req_valid); end
      cycle();
    end
    total++;
    if (writes_seen - w0 !== 2 || outstanding !== 3'd0)
      begin bad++; $display("FAIL halt_complete got=%0d/%0d want=2/0", writes_seen - w0, outstanding); end
    halt = 1'b0;
    @(negedge clock);
    while (!mem_req_valid && w < 5) begin cycle(); @(negedge clock); w++; end
    total++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h10)
      begin bad++; $display("FAIL halt_resume got=%b/%h want=1/00000010", mem_req_valid, mem_req_addr); end
    cycle();
    drain(ok);
    total++; if (!ok) begin bad++; $display("FAIL halt_drain got=%0d want=0", outstanding); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; squash = 1'b0; squash_pc = '0;
    mem_req_ready = 1'b0; ib_pop = 1'b0;
    test_reset();
    test_fill();
    test_credit();
    test_stall();
    test_squash();
    test_squash_rsp();
    test_halt();
    repeat (3) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
